// File: rtl/pad_sensor_interface_if.sv
// -----------------------------------------------------------------------------
// pad_sensor_if
//   Bundles the pad-side and controller-side signals of pad_sensor_interface.
//
//   Signals:
//     iSENSOR_n     [14:0]  raw pad sensors, active-low, asynchronous
//     out_game      [31:0]  target word from the game controller, active-low
//     sensor_input  [31:0]  conditioned sensor word, active-low
//     oPAD_LED      [2:0]   active-high LED drive, [0] pad1 .. [2] pad3
//     oHIT_STB              one-cycle pulse when a pad becomes hit
//     oHIT_PAD      [1:0]   pad id (1..3) of the last strobe, 0 after reset
//     stretch_state [29:0]  debug view of the per-bit stretch FSMs, 2 bits
//                           per sensor bit, bit i at [2*i+1:2*i]
//
//   Handshake: there is no backpressure anywhere. oHIT_STB acts as the only
//   valid qualifier; it is high for exactly one clock and oHIT_PAD is
//   meaningful in that clock (and holds afterwards). All other outputs are
//   level signals that are always valid.
//
//   Modports: slave is the block itself, master is whoever drives the pads
//   and the controller word.
// -----------------------------------------------------------------------------
interface pad_sensor_if;
    logic [14:0] iSENSOR_n;
    logic [31:0] out_game;
    logic [31:0] sensor_input;
    logic [2:0]  oPAD_LED;
    logic        oHIT_STB;
    logic [1:0]  oHIT_PAD;
    logic [29:0] stretch_state;

    modport slave (
        input  iSENSOR_n,
        input  out_game,
        output sensor_input,
        output oPAD_LED,
        output oHIT_STB,
        output oHIT_PAD,
        output stretch_state
    );

    modport master (
        output iSENSOR_n,
        output out_game,
        input  sensor_input,
        input  oPAD_LED,
        input  oHIT_STB,
        input  oHIT_PAD,
        input  stretch_state
    );
endinterface

// File: rtl/pad_sensor_interface.sv
// -----------------------------------------------------------------------------
// pad_sensor_interface
//   Front end between the drum pads and the VGA game controller.
//   Sensor path: 2-flop sync -> per-bit debounce -> per-bit pulse stretch ->
//   registered 32-bit active-low sensor word, plus a hit strobe whenever a
//   pad goes from inactive to active. LED path: out_game[2:0] is registered
//   and decoded one-hot into the pad LED drives.
//
//   Ports:
//     iVGA_CLK  sole clock, rising edge
//     iRST_n    asynchronous active-low reset
//     pad_bus   pad_sensor_if.slave (sensors, controller word, outputs)
//
//   Configuration macro PAD_HOLD_EN:
//     defined   - released bits are held low for HOLD_CYCLES extra cycles
//     undefined - no stretch; the stretched bit is a registered copy of the
//                 debounced bit and HOLD_CYCLES is unused
//
//   Pad mapping: pad1 = [14:10], pad2 = [9:5], pad3 = [4:0].
// -----------------------------------------------------------------------------
module pad_sensor_interface #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 2500000,
    parameter int CNT_W           = 22
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    pad_sensor_if.slave pad_bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_HOLD = 2'd2
    } stretch_state_e;

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [14:0] sync1;
    logic [14:0] sync2;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= pad_bus.iSENSOR_n;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce: a change is accepted only after the synced value has
    // differed from the accepted state for DEBOUNCE_CYCLES consecutive
    // cycles; any cycle of agreement restarts the count.
    // ------------------------------------------------------------------
    logic [14:0]      deb;
    logic [CNT_W-1:0] deb_cnt [15];

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            deb <= '1;
            for (int i = 0; i < 15; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_MAX) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stretch
    // ------------------------------------------------------------------
    logic [14:0] str;

`ifdef PAD_HOLD_EN
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

    stretch_state_e   st       [15];
    logic [CNT_W-1:0] hold_cnt [15];

    // Per bit: HELD while pressed, HOLD counts HOLD_CYCLES after release,
    // IDLE is the only state that drives the bit high. A re-press during
    // HOLD returns to HELD and restarts the hold window on the next release.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            str <= '1;
            for (int i = 0; i < 15; i++) begin
                st[i]       <= ST_IDLE;
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                case (st[i])
                    ST_IDLE: begin
                        if (!deb[i]) begin
                            st[i]  <= ST_HELD;
                            str[i] <= 1'b0;
                        end
                    end
                    ST_HELD: begin
                        if (deb[i]) begin
                            st[i]       <= ST_HOLD;
                            hold_cnt[i] <= '0;
                        end
                    end
                    ST_HOLD: begin
                        if (!deb[i]) begin
                            st[i]       <= ST_HELD;
                            hold_cnt[i] <= '0;
                        end else if (hold_cnt[i] == HOLD_MAX) begin
                            st[i]       <= ST_IDLE;
                            str[i]      <= 1'b1;
                            hold_cnt[i] <= '0;
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        st[i]       <= ST_IDLE;
                        str[i]      <= 1'b1;
                        hold_cnt[i] <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        pad_bus.stretch_state = '0;
        for (int i = 0; i < 15; i++) begin
            pad_bus.stretch_state[2*i +: 2] = st[i];
        end
    end
`else
    localparam int unused_hold_cycles = HOLD_CYCLES;

    // Kept as a register so press latency matches the stretched build.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            str <= '1;
        end else begin
            str <= deb;
        end
    end

    always_comb begin
        pad_bus.stretch_state = '0;
        for (int i = 0; i < 15; i++) begin
            pad_bus.stretch_state[2*i +: 2] = str[i] ? ST_IDLE : ST_HELD;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output word and hit strobe
    // ------------------------------------------------------------------
    logic [31:0] sensor_q;
    logic        hit_stb_q;
    logic [1:0]  hit_pad_q;
    logic [2:0]  act_next;
    logic [2:0]  act_cur;
    logic [2:0]  act_rise;

    // [0] pad1, [1] pad2, [2] pad3. act_cur comes from the word already on
    // sensor_input, so the strobe lines up with the first low bit there.
    assign act_next = {~&str[4:0],      ~&str[9:5],      ~&str[14:10]};
    assign act_cur  = {~&sensor_q[4:0], ~&sensor_q[9:5], ~&sensor_q[14:10]};
    assign act_rise = act_next & ~act_cur;

    // Lower-priority pads rising together with a higher one are dropped:
    // next cycle they are already active and cannot rise again.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            sensor_q  <= '1;
            hit_stb_q <= 1'b0;
            hit_pad_q <= 2'd0;
        end else begin
            sensor_q  <= {17'h1FFFF, str};
            hit_stb_q <= |act_rise;
            if (act_rise[0]) begin
                hit_pad_q <= 2'd1;
            end else if (act_rise[1]) begin
                hit_pad_q <= 2'd2;
            end else if (act_rise[2]) begin
                hit_pad_q <= 2'd3;
            end
        end
    end

    // ------------------------------------------------------------------
    // LED decode: exactly one zero in out_game[2:0] lights that pad.
    // ------------------------------------------------------------------
    logic [2:0] game_q;
    logic [2:0] led_q;
    logic       unused_game_bits;

    assign unused_game_bits = ^pad_bus.out_game[31:3];

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            game_q <= 3'b111;
            led_q  <= 3'b000;
        end else begin
            game_q <= pad_bus.out_game[2:0];
            case (game_q)
                3'b110:  led_q <= 3'b001;
                3'b101:  led_q <= 3'b010;
                3'b011:  led_q <= 3'b100;
                default: led_q <= 3'b000;
            endcase
        end
    end

    assign pad_bus.sensor_input = sensor_q;
    assign pad_bus.oHIT_STB     = hit_stb_q;
    assign pad_bus.oHIT_PAD     = hit_pad_q;
    assign pad_bus.oPAD_LED     = led_q;

endmodule
